// File: rtl/multdiv_unit_if.sv
// Operand, start and result bundle between the execute stage and the iterative multiply/divide unit.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit with
// a fixed 32-step latency; a new start pulse in any state aborts and restarts the unit.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [5:0]         r_count;
    logic [2*WIDTH:0]   r_work;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg;
    logic               r_div0;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;

    logic               w_start;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_upper_ext;
    logic [WIDTH:0]     w_mcand_ext;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH:0]   w_mul_next;
    logic [WIDTH-1:0]   w_rem_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH:0]   w_div_next;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_sign_bits;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_div_result;
    logic               w_div_exc;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (r_count == 6'd31);
    assign w_abs_a = bus.data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - bus.data_operandA) : bus.data_operandA;
    assign w_abs_b = bus.data_operandB[WIDTH-1] ? ({WIDTH{1'b0}} - bus.data_operandB) : bus.data_operandB;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a start pulse overrides any state, multiply taking priority
    always_comb begin
        w_next_state = r_state;
        if (bus.ctrl_MULT) begin
            w_next_state = S_MUL;
        end else if (bus.ctrl_DIV) begin
            w_next_state = S_DIV;
        end else begin
            case (r_state)
                S_IDLE:        w_next_state = S_IDLE;
                S_MUL, S_DIV:  w_next_state = w_last ? S_DONE : r_state;
                S_DONE:        w_next_state = S_IDLE;
                default:       w_next_state = S_IDLE;
            endcase
        end
    end

    // Booth step: the add is done one bit wider so the arithmetic shift keeps the true sign
    always_comb begin
        w_upper_ext = {r_work[2*WIDTH], r_work[2*WIDTH:WIDTH+1]};
        w_mcand_ext = {r_opnd[WIDTH-1], r_opnd};
        case (r_work[1:0])
            2'b01:   w_mul_sum = w_upper_ext + w_mcand_ext;
            2'b10:   w_mul_sum = w_upper_ext - w_mcand_ext;
            default: w_mul_sum = w_upper_ext;
        endcase
        w_mul_next = {w_mul_sum, r_work[WIDTH:1]};
    end

    // Restoring step: remainder shifted in 32 bits cannot overflow since it stays below the divisor
    always_comb begin
        w_rem_shift = r_work[2*WIDTH-2:WIDTH-1];
        w_div_diff  = {1'b0, w_rem_shift} - {1'b0, r_opnd};
        if (w_div_diff[WIDTH]) begin
            w_div_next = {1'b0, w_rem_shift, r_work[WIDTH-2:0], 1'b0};
        end else begin
            w_div_next = {1'b0, w_div_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
        end
    end

    // Final-step result formatting for both operations
    always_comb begin
        w_product   = w_mul_next[2*WIDTH:1];
        w_sign_bits = w_product[2*WIDTH-1:WIDTH-1];
        w_mul_exc   = ~((&w_sign_bits) | (~|w_sign_bits));
        w_quot      = w_div_next[WIDTH-1:0];
        if (r_div0) begin
            w_div_result = {WIDTH{1'b0}};
            w_div_exc    = 1'b1;
        end else if (r_ovf) begin
            w_div_result = {1'b1, {(WIDTH-1){1'b0}}};
            w_div_exc    = 1'b1;
        end else if (r_neg) begin
            w_div_result = {WIDTH{1'b0}} - w_quot;
            w_div_exc    = 1'b0;
        end else begin
            w_div_result = w_quot;
            w_div_exc    = 1'b0;
        end
    end

    // Operand latch, step counter and iteration register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_work  <= {(2*WIDTH+1){1'b0}};
            r_opnd  <= {WIDTH{1'b0}};
            r_count <= 6'd0;
            r_neg   <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.ctrl_MULT) begin
            r_work  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            r_opnd  <= bus.data_operandA;
            r_count <= 6'd0;
        end else if (bus.ctrl_DIV) begin
            r_work  <= {1'b0, {WIDTH{1'b0}}, w_abs_a};
            r_opnd  <= w_abs_b;
            r_count <= 6'd0;
            r_neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            r_div0  <= (bus.data_operandB == {WIDTH{1'b0}});
            r_ovf   <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (bus.data_operandB == {WIDTH{1'b1}});
        end else if (r_state == S_MUL) begin
            r_work  <= w_mul_next;
            r_count <= r_count + 6'd1;
        end else if (r_state == S_DIV) begin
            r_work  <= w_div_next;
            r_count <= r_count + 6'd1;
        end else begin
            r_work  <= r_work;
            r_count <= r_count;
        end
    end

    // Result registers load only on an uninterrupted final step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result    <= {WIDTH{1'b0}};
            r_exception <= 1'b0;
        end else if (!w_start && w_last && (r_state == S_MUL)) begin
            r_result    <= w_product[WIDTH-1:0];
            r_exception <= w_mul_exc;
        end else if (!w_start && w_last && (r_state == S_DIV)) begin
            r_result    <= w_div_result;
            r_exception <= w_div_exc;
        end else begin
            r_result    <= r_result;
            r_exception <= r_exception;
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = (r_state == S_DONE);
    assign bus.busy           = (r_state == S_MUL) || (r_state == S_DIV);

endmodule
